// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, ALU codes, forward selects and widths for the MIPS core
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2a;

    localparam logic [3:0] ALU_AND = 4'h0;
    localparam logic [3:0] ALU_OR  = 4'h1;
    localparam logic [3:0] ALU_ADD = 4'h2;
    localparam logic [3:0] ALU_SLL = 4'h3;
    localparam logic [3:0] ALU_SUB = 4'h6;
    localparam logic [3:0] ALU_SLT = 4'h7;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/control_unit.sv
// rtl/control_unit.sv - main control decode from opcode/funct and the branch compare result
module control_unit (
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       equal,
    output logic [3:0] alu_op,
    output logic       alu_a_sel,
    output logic       alu_b_sel,
    output logic [3:0] mem_we,
    output logic       jump_raw,
    output logic       reg_d_addr_sel,
    output logic       reg_d_data_sel,
    output logic       reg_d_we
);
    import mips_pkg::*;

    always_comb begin
        alu_op         = ALU_ADD;
        alu_a_sel      = 1'b0;
        alu_b_sel      = 1'b0;
        mem_we         = 4'h0;
        jump_raw       = 1'b0;
        reg_d_addr_sel = 1'b0;
        reg_d_data_sel = 1'b0;
        reg_d_we       = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                reg_d_addr_sel = 1'b1;
                reg_d_we       = 1'b1;
                case (funct)
                    FN_SLL: begin
                        alu_op    = ALU_SLL;
                        alu_a_sel = 1'b1;   // shamt replaces rs as operand A
                    end
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: reg_d_we = 1'b0;
                endcase
            end
            OP_ADDI: begin
                alu_b_sel = 1'b1;
                reg_d_we  = 1'b1;
            end
            OP_LW: begin
                alu_b_sel      = 1'b1;
                reg_d_data_sel = 1'b1;
                reg_d_we       = 1'b1;
            end
            OP_SW: begin
                alu_b_sel = 1'b1;
                mem_we    = 4'hf;
            end
            OP_BEQ: begin
                alu_op   = ALU_SUB;
                jump_raw = equal;
            end
            OP_BNE: begin
                alu_op   = ALU_SUB;
                jump_raw = ~equal;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_hazard.sv
// rtl/decode_hazard.sv - ID stall detection, EX forward selects and forwarded branch-compare operands
module decode_hazard #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW
) (
    input  logic              id_valid,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic [5:0]        opcode,
    input  logic              ex_valid,
    input  logic              reg_d_we_ex,
    input  logic              reg_d_data_sel_ex,
    input  logic [REG_AW-1:0] reg_d_addr_ex,
    input  logic              mem_reg_d_we,
    input  logic [REG_AW-1:0] mem_reg_d_addr,
    input  logic [DATA_W-1:0] mem_reg_d_data,
    input  logic [DATA_W-1:0] reg_s_data,
    input  logic [DATA_W-1:0] reg_t_data,
    output logic              stall,
    output logic [1:0]        fwd_s_sel,
    output logic [1:0]        fwd_t_sel,
    output logic [DATA_W-1:0] cmp_s,
    output logic [DATA_W-1:0] cmp_t
);
    import mips_pkg::*;

    logic ex_wr, ex_hit_s, ex_hit_t, mem_hit_s, mem_hit_t;
    logic is_branch, load_use, branch_hz;

    // Register 0 is hardwired, so a write to it is never a producer.
    assign ex_wr     = ex_valid & reg_d_we_ex & (reg_d_addr_ex != '0);
    assign ex_hit_s  = ex_wr & (reg_d_addr_ex == rs);
    assign ex_hit_t  = ex_wr & (reg_d_addr_ex == rt);
    assign mem_hit_s = mem_reg_d_we & (mem_reg_d_addr == rs) & (rs != '0);
    assign mem_hit_t = mem_reg_d_we & (mem_reg_d_addr == rt) & (rt != '0);

    assign is_branch = (opcode == OP_BEQ) | (opcode == OP_BNE);
    assign load_use  = reg_d_data_sel_ex & (ex_hit_s | ex_hit_t);
    assign branch_hz = is_branch & (ex_hit_s | ex_hit_t);
    assign stall     = id_valid & (load_use | branch_hz);

    assign cmp_s = mem_hit_s ? mem_reg_d_data : reg_s_data;
    assign cmp_t = mem_hit_t ? mem_reg_d_data : reg_t_data;

    // The EX producer is newer than the MEM one, so it takes priority.
    assign fwd_s_sel = ex_hit_s ? FWD_MEM : (mem_hit_s ? FWD_WB : FWD_REG);
    assign fwd_t_sel = ex_hit_t ? FWD_MEM : (mem_hit_t ? FWD_WB : FWD_REG);

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - ID stage: decode, branch resolve, hazards and EX pipeline registers
module decode_stage #(
    parameter int DATA_W       = mips_pkg::DATA_W,
    parameter int REG_AW       = mips_pkg::REG_AW,
    parameter int TARGET_SHIFT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [DATA_W-1:0] pc,
    input  logic [31:0]       ir,
    output logic [REG_AW-1:0] reg_s_addr,
    output logic [REG_AW-1:0] reg_t_addr,
    input  logic [DATA_W-1:0] reg_s_data,
    input  logic [DATA_W-1:0] reg_t_data,
    input  logic              mem_reg_d_we,
    input  logic [REG_AW-1:0] mem_reg_d_addr,
    input  logic [DATA_W-1:0] mem_reg_d_data,
    output logic [DATA_W-1:0] target,
    output logic              jump,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [3:0]        alu_op_ex,
    output logic              alu_a_sel_ex,
    output logic              alu_b_sel_ex,
    output logic [3:0]        mem_we_ex,
    output logic              reg_d_we_ex,
    output logic              reg_d_data_sel_ex,
    output logic [REG_AW-1:0] reg_d_addr_ex,
    output logic [DATA_W-1:0] imm_ex,
    output logic [DATA_W-1:0] reg_s_data_ex,
    output logic [DATA_W-1:0] reg_t_data_ex,
    output logic [1:0]        fwd_s_sel_ex,
    output logic [1:0]        fwd_t_sel_ex
);
    logic [5:0]        opcode;
    logic [REG_AW-1:0] rs, rt, rd;
    logic [DATA_W-1:0] imm_sext, cmp_s, cmp_t;
    logic [1:0]        fwd_s_sel, fwd_t_sel;
    logic              stall, equal, xfer;
    logic [3:0]        alu_op, mem_we;
    logic              alu_a_sel, alu_b_sel, jump_raw;
    logic              reg_d_addr_sel, reg_d_data_sel, reg_d_we;

    assign opcode   = ir[31:26];
    assign rs       = REG_AW'(ir[25:21]);
    assign rt       = REG_AW'(ir[20:16]);
    assign rd       = REG_AW'(ir[15:11]);
    assign imm_sext = {{(DATA_W-16){ir[15]}}, ir[15:0]};

    assign reg_s_addr = rs;
    assign reg_t_addr = rt;
    assign target     = pc + (imm_sext << TARGET_SHIFT);

    decode_hazard #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_hazard (
        .id_valid          (id_valid),
        .rs                (rs),
        .rt                (rt),
        .opcode            (opcode),
        .ex_valid          (ex_valid),
        .reg_d_we_ex       (reg_d_we_ex),
        .reg_d_data_sel_ex (reg_d_data_sel_ex),
        .reg_d_addr_ex     (reg_d_addr_ex),
        .mem_reg_d_we      (mem_reg_d_we),
        .mem_reg_d_addr    (mem_reg_d_addr),
        .mem_reg_d_data    (mem_reg_d_data),
        .reg_s_data        (reg_s_data),
        .reg_t_data        (reg_t_data),
        .stall             (stall),
        .fwd_s_sel         (fwd_s_sel),
        .fwd_t_sel         (fwd_t_sel),
        .cmp_s             (cmp_s),
        .cmp_t             (cmp_t)
    );

    assign equal = (cmp_s == cmp_t);

    control_unit u_ctrl (
        .opcode         (opcode),
        .funct          (ir[5:0]),
        .equal          (equal),
        .alu_op         (alu_op),
        .alu_a_sel      (alu_a_sel),
        .alu_b_sel      (alu_b_sel),
        .mem_we         (mem_we),
        .jump_raw       (jump_raw),
        .reg_d_addr_sel (reg_d_addr_sel),
        .reg_d_data_sel (reg_d_data_sel),
        .reg_d_we       (reg_d_we)
    );

    assign id_ready = ex_ready & ~stall;
    assign xfer     = id_valid & id_ready;
    // A stalled or back-pressured branch must not redirect; it is re-evaluated later.
    assign jump     = jump_raw & id_valid & ~stall & ex_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid          <= 1'b0;
            alu_op_ex         <= '0;
            alu_a_sel_ex      <= 1'b0;
            alu_b_sel_ex      <= 1'b0;
            mem_we_ex         <= '0;
            reg_d_we_ex       <= 1'b0;
            reg_d_data_sel_ex <= 1'b0;
            reg_d_addr_ex     <= '0;
            imm_ex            <= '0;
            reg_s_data_ex     <= '0;
            reg_t_data_ex     <= '0;
            fwd_s_sel_ex      <= '0;
            fwd_t_sel_ex      <= '0;
        end else if (ex_ready) begin
            if (xfer) begin
                ex_valid          <= 1'b1;
                alu_op_ex         <= alu_op;
                alu_a_sel_ex      <= alu_a_sel;
                alu_b_sel_ex      <= alu_b_sel;
                mem_we_ex         <= mem_we;
                reg_d_we_ex       <= reg_d_we;
                reg_d_data_sel_ex <= reg_d_data_sel;
                reg_d_addr_ex     <= reg_d_addr_sel ? rd : rt;
                imm_ex            <= imm_sext;
                reg_s_data_ex     <= reg_s_data;
                reg_t_data_ex     <= reg_t_data;
                fwd_s_sel_ex      <= fwd_s_sel;
                fwd_t_sel_ex      <= fwd_t_sel;
            end else begin
                ex_valid    <= 1'b0;
                reg_d_we_ex <= 1'b0;
                mem_we_ex   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, id_valid, ex_ready, mem_reg_d_we;
    logic [31:0] pc, ir, reg_s_data, reg_t_data, mem_reg_d_data;
    logic [4:0]  mem_reg_d_addr;

    logic        id_ready, jump, ex_valid, alu_a_sel_ex, alu_b_sel_ex, reg_d_we_ex, reg_d_data_sel_ex;
    logic [4:0]  reg_s_addr, reg_t_addr, reg_d_addr_ex;
    logic [31:0] target, imm_ex, reg_s_data_ex, reg_t_data_ex;
    logic [3:0]  alu_op_ex, mem_we_ex;
    logic [1:0]  fwd_s_sel_ex, fwd_t_sel_ex;

    logic        d2_id_ready, d2_jump, d2_ex_valid, d2_alu_a_sel_ex, d2_alu_b_sel_ex, d2_reg_d_we_ex, d2_reg_d_data_sel_ex;
    logic [4:0]  d2_reg_s_addr, d2_reg_t_addr, d2_reg_d_addr_ex;
    logic [31:0] d2_target, d2_imm_ex, d2_reg_s_data_ex, d2_reg_t_data_ex;
    logic [3:0]  d2_alu_op_ex, d2_mem_we_ex;
    logic [1:0]  d2_fwd_s_sel_ex, d2_fwd_t_sel_ex;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready), .pc(pc), .ir(ir),
        .reg_s_addr(reg_s_addr), .reg_t_addr(reg_t_addr), .reg_s_data(reg_s_data), .reg_t_data(reg_t_data),
        .mem_reg_d_we(mem_reg_d_we), .mem_reg_d_addr(mem_reg_d_addr), .mem_reg_d_data(mem_reg_d_data),
        .target(target), .jump(jump), .ex_ready(ex_ready), .ex_valid(ex_valid), .alu_op_ex(alu_op_ex),
        .alu_a_sel_ex(alu_a_sel_ex), .alu_b_sel_ex(alu_b_sel_ex), .mem_we_ex(mem_we_ex),
        .reg_d_we_ex(reg_d_we_ex), .reg_d_data_sel_ex(reg_d_data_sel_ex), .reg_d_addr_ex(reg_d_addr_ex),
        .imm_ex(imm_ex), .reg_s_data_ex(reg_s_data_ex), .reg_t_data_ex(reg_t_data_ex),
        .fwd_s_sel_ex(fwd_s_sel_ex), .fwd_t_sel_ex(fwd_t_sel_ex)
    );

    decode_stage #(.TARGET_SHIFT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(d2_id_ready), .pc(pc), .ir(ir),
        .reg_s_addr(d2_reg_s_addr), .reg_t_addr(d2_reg_t_addr), .reg_s_data(reg_s_data), .reg_t_data(reg_t_data),
        .mem_reg_d_we(mem_reg_d_we), .mem_reg_d_addr(mem_reg_d_addr), .mem_reg_d_data(mem_reg_d_data),
        .target(d2_target), .jump(d2_jump), .ex_ready(ex_ready), .ex_valid(d2_ex_valid), .alu_op_ex(d2_alu_op_ex),
        .alu_a_sel_ex(d2_alu_a_sel_ex), .alu_b_sel_ex(d2_alu_b_sel_ex), .mem_we_ex(d2_mem_we_ex),
        .reg_d_we_ex(d2_reg_d_we_ex), .reg_d_data_sel_ex(d2_reg_d_data_sel_ex), .reg_d_addr_ex(d2_reg_d_addr_ex),
        .imm_ex(d2_imm_ex), .reg_s_data_ex(d2_reg_s_data_ex), .reg_t_data_ex(d2_reg_t_data_ex),
        .fwd_s_sel_ex(d2_fwd_s_sel_ex), .fwd_t_sel_ex(d2_fwd_t_sel_ex)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; id_valid = 1'b1; ex_ready = 1'b1;
        ir = r_ins(5'd1, 5'd2, 5'd3, 6'h20); pc = 32'h0;
        reg_s_data = 32'h0; reg_t_data = 32'h0;
        mem_reg_d_we = 1'b0; mem_reg_d_addr = 5'd0; mem_reg_d_data = 32'h0;

        // reset with a valid instruction presented
        tick(); tick();
        check("rst_ex_valid", ex_valid, 0);
        check("rst_addr", reg_d_addr_ex, 0);
        check("rst_we", reg_d_we_ex, 0);
        check("rst_alu_op", alu_op_ex, 0);
        check("rst_imm", imm_ex, 0);
        check("rst_fwd_s", fwd_s_sel_ex, 0);
        rst_n = 1'b1;
        tick();
        check("rel_ex_valid", ex_valid, 1);
        check("rel_addr", reg_d_addr_ex, 3);
        check("rel_we", reg_d_we_ex, 1);
        check("rel_alu_op", alu_op_ex, 4'h2);
        check("rel_imm", imm_ex, 32'h1820);

        // load-use: lw $5,0($1) then add $6,$5,$2
        ir = i_ins(6'h23, 5'd1, 5'd5, 16'h0);
        #1 check("lw_ready", id_ready, 1);
        tick();
        check("lw_data_sel", reg_d_data_sel_ex, 1);
        check("lw_addr", reg_d_addr_ex, 5);
        ir = r_ins(5'd5, 5'd2, 5'd6, 6'h20);
        #1 check("lu_stall_ready", id_ready, 0);
        tick();
        check("lu_bubble_valid", ex_valid, 0);
        check("lu_bubble_we", reg_d_we_ex, 0);
        mem_reg_d_we = 1'b1; mem_reg_d_addr = 5'd5;
        #1 check("lu_ready_again", id_ready, 1);
        tick();
        check("lu_issue_valid", ex_valid, 1);
        check("lu_issue_addr", reg_d_addr_ex, 6);
        check("lu_fwd_s", fwd_s_sel_ex, 2);
        check("lu_fwd_t", fwd_t_sel_ex, 0);

        // forward priority: EX beats MEM, and $0 never forwards
        mem_reg_d_we = 1'b0;
        ir = r_ins(5'd1, 5'd2, 5'd4, 6'h20);
        tick();
        ir = r_ins(5'd4, 5'd0, 5'd9, 6'h22);
        mem_reg_d_we = 1'b1; mem_reg_d_addr = 5'd4;
        tick();
        check("prio_fwd_s", fwd_s_sel_ex, 1);
        check("prio_fwd_t", fwd_t_sel_ex, 0);
        check("prio_alu_sub", alu_op_ex, 4'h6);
        mem_reg_d_we = 1'b0;
        ir = r_ins(5'd1, 5'd2, 5'd0, 6'h20);
        tick();
        ir = r_ins(5'd0, 5'd1, 5'd10, 6'h20);
        mem_reg_d_we = 1'b1; mem_reg_d_addr = 5'd0;
        tick();
        check("zero_fwd_s", fwd_s_sel_ex, 0);
        check("zero_fwd_t", fwd_t_sel_ex, 0);
        check("zero_addr", reg_d_addr_ex, 10);

        // branch resolve in ID with MEM forwarding on the compare
        mem_reg_d_we = 1'b0;
        ir = i_ins(6'h04, 5'd7, 5'd8, 16'd4); pc = 32'h100;
        reg_s_data = 32'd9; reg_t_data = 32'd9;
        #1;
        check("beq_s_addr", reg_s_addr, 7);
        check("beq_t_addr", reg_t_addr, 8);
        check("beq_jump", jump, 1);
        check("beq_target", target, 32'h104);
        check("beq_ready", id_ready, 1);
        mem_reg_d_we = 1'b1; mem_reg_d_addr = 5'd7; mem_reg_d_data = 32'd1;
        #1 check("beq_fwd_nojump", jump, 0);
        mem_reg_d_we = 1'b0;
        tick();
        check("beq_ex_we", reg_d_we_ex, 0);

        // branch operand produced by the instruction in EX
        ir = r_ins(5'd1, 5'd2, 5'd7, 6'h20);
        tick();
        ir = i_ins(6'h04, 5'd7, 5'd8, 16'd4);
        #1;
        check("bhz_ready", id_ready, 0);
        check("bhz_jump", jump, 0);
        tick();
        check("bhz_bubble", ex_valid, 0);
        #1;
        check("bhz_ready_after", id_ready, 1);
        check("bhz_jump_after", jump, 1);
        tick();

        // backpressure for three cycles
        ir = r_ins(5'd1, 5'd2, 5'd11, 6'h20);
        tick();
        check("bp_pre_addr", reg_d_addr_ex, 11);
        ex_ready = 1'b0;
        ir = i_ins(6'h04, 5'd1, 5'd2, 16'd4);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready", id_ready, 0);
            check("bp_jump", jump, 0);
            tick();
            check("bp_hold_addr", reg_d_addr_ex, 11);
            check("bp_hold_valid", ex_valid, 1);
            check("bp_hold_we", reg_d_we_ex, 1);
        end
        ex_ready = 1'b1;
        #1;
        check("bp_rel_ready", id_ready, 1);
        check("bp_rel_jump", jump, 1);
        tick();
        check("bp_xfer_addr", reg_d_addr_ex, 2);
        check("bp_xfer_we", reg_d_we_ex, 0);
        check("bp_xfer_imm", imm_ex, 32'h4);
        check("bp_xfer_valid", ex_valid, 1);

        // store then bubble: a bubble never writes memory
        ir = i_ins(6'h2b, 5'd1, 5'd2, 16'h0);
        tick();
        check("sw_mem_we", mem_we_ex, 4'hf);
        id_valid = 1'b0;
        ir = i_ins(6'h04, 5'd1, 5'd2, 16'd4);
        #1 check("novalid_jump", jump, 0);
        tick();
        check("bubble_mem_we", mem_we_ex, 0);
        check("bubble_valid", ex_valid, 0);

        // target arithmetic
        id_valid = 1'b1;
        pc = 32'hFFFF_FFFC; ir = i_ins(6'h04, 5'd1, 5'd2, 16'd8);
        #1 check("target_wrap", target, 32'h4);
        pc = 32'h100; ir = i_ins(6'h04, 5'd1, 5'd2, 16'hFFFC);
        #1 check("target_neg", target, 32'hFC);
        pc = 32'h200; ir = i_ins(6'h04, 5'd1, 5'd2, 16'd1);
        #1;
        check("target_shift2", d2_target, 32'h204);
        check("target_shift0", target, 32'h201);

        // reset wins over a pending transfer
        ir = r_ins(5'd1, 5'd2, 5'd12, 6'h20);
        rst_n = 1'b0;
        tick();
        check("rst_mid_valid", ex_valid, 0);
        check("rst_mid_addr", reg_d_addr_ex, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Parametrised successor to the ID stage of the pipelined MIPS core.
- Decodes the instruction word and drives register-file read addresses.
- Resolves branches and jumps in ID, with MEM-stage operand forwarding on the compare.
- Detects load-use and branch-operand hazards, computes EX forwarding selects, and registers everything into EX behind a valid/ready handshake with synchronous reset.

Parameters:
- DATA_W, 32, datapath, PC and immediate-extension width
- REG_AW, 5, register address width
- TARGET_SHIFT, 0, left shift applied to the sign-extended immediate before adding it to pc for the branch target

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  pc/ir hold a valid instruction
- id_ready  out  1  ID accepts the instruction this cycle
- pc  in  DATA_W  PC value used for the branch-target add
- ir  in  32  instruction word
- reg_s_addr, reg_t_addr  out  REG_AW  register-file read addresses: ir[25:21], ir[20:16]
- reg_s_data, reg_t_data  in  DATA_W  register-file read data
- mem_reg_d_we  in  1  MEM-stage instruction writes a register
- mem_reg_d_addr  in  REG_AW  MEM-stage destination register
- mem_reg_d_data  in  DATA_W  MEM-stage result
- target  out  DATA_W  pc + (sext(ir[15:0]) << TARGET_SHIFT), modulo 2^DATA_W
- jump  out  1  redirect fetch to target; also the IF flush request
- ex_ready  in  1  EX can accept a new instruction
- ex_valid  out  1  EX registers hold a valid instruction
- alu_op_ex  out  4  registered control-unit output
- alu_a_sel_ex, alu_b_sel_ex  out  1  registered control-unit outputs
- mem_we_ex  out  4  registered control-unit output
- reg_d_we_ex  out  1  registered control-unit output
- reg_d_data_sel_ex  out  1  registered control-unit output; 1 = load (writeback from memory)
- reg_d_addr_ex  out  REG_AW  rd if reg_d_addr_sel else rt
- imm_ex  out  DATA_W  sign-extended ir[15:0]
- reg_s_data_ex, reg_t_data_ex  out  DATA_W  register-file data
- fwd_s_sel_ex, fwd_t_sel_ex  out  2  EX operand source: 0 regfile, 1 MEM-stage ALU result, 2 WB result

Behaviour:
- Control decoding uses the existing control unit.
  - Inputs: opcode ir[31:26], funct ir[5:0], equal.
  - Outputs: alu_op, alu_a_sel, alu_b_sel, mem_we, jump_raw, reg_d_addr_sel, reg_d_data_sel, reg_d_we.
- Branch compare (equal):
  - Compares the forwarded s and t operands.
  - An operand takes mem_reg_d_data when mem_reg_d_we is set, mem_reg_d_addr equals the read address, and that address is nonzero; otherwise it takes the regfile data.
- load_use stall: ex_valid & reg_d_we_ex & reg_d_data_sel_ex & reg_d_addr_ex!=0 & (reg_d_addr_ex==rs | reg_d_addr_ex==rt).
- branch_hz stall: opcode is 6'h04 or 6'h05 & ex_valid & reg_d_we_ex & reg_d_addr_ex!=0 & matches rs or rt.
- stall = id_valid & (load_use | branch_hz).
- Handshake:
  - id_ready = ex_ready & ~stall.
  - Transfer occurs when id_valid & id_ready.
- jump = jump_raw & id_valid & ~stall & ex_ready. A stalled branch never redirects; it is re-evaluated on the next cycle.
- EX register update, on posedge clk:
  - rst_n=0: every _ex output, including the selects, clears to 0 and ex_valid clears to 0. This takes priority mid-stall or mid-transfer.
  - ex_ready=0: all _ex registers hold.
  - Transfer: all fields load and ex_valid<=1.
  - ex_ready=1 without transfer: ex_valid<=0 (bubble); reg_d_we_ex<=0 and mem_we_ex<=0, so a bubble never writes. Other fields are don't-care.
- Forward selects, computed at transfer for each of s and t (register 0 never forwarded):
  - 1 if ex_valid & reg_d_we_ex & reg_d_addr_ex==addr.
  - Else 2 if mem_reg_d_we & mem_reg_d_addr==addr.
  - Else 0.
  - The newer producer (EX) wins.
- Latency: one cycle from ID acceptance to the EX outputs. target and jump are combinational in the same cycle.

Decomposition:
- Shared package mips_pkg:
  - Opcode constants: OP_BEQ, OP_BNE.
  - FWD_* select encodings.
  - Widths: DATA_W, REG_AW.
- One sub-module, decode_hazard (combinational):
  - Inputs: rs, rt, opcode, the EX destination fields, the MEM forwarding fields.
  - Outputs: stall, both fwd selects, both forwarded compare operands.
- decode_stage instantiates decode_hazard and the control unit and holds the EX registers.

Test Plan:
- Reset: hold rst_n=0 with id_valid=1 and add $3,$1,$2 -> ex_valid=0, all _ex outputs 0. Release rst_n -> ex_valid=1 after 1 clk, reg_d_addr_ex=3.
- Load-use: lw $5,0($1) then add $6,$5,$2 -> id_ready=0 for exactly 1 cycle, one bubble with ex_valid=0 and reg_d_we_ex=0, then add issues with fwd_s_sel_ex=2.
- Forward priority: add $4,... in EX and $4 in MEM, next instruction reads $4 -> fwd_s_sel_ex=1. Repeat with $0 -> fwd_s_sel_ex=0.
- Branch:
  - beq $7,$8,+4 with pc=0x100, reg_s_data=reg_t_data=9 -> jump=1, target=0x104.
  - Same beq with mem_reg_d_addr=7 and mem_reg_d_data=1 -> jump=0.
  - Producer of $7 in EX -> 1-cycle stall, jump=0 during the stall.
- Backpressure: ex_ready=0 for 3 cycles mid-stream -> _ex outputs stable, id_ready=0, jump=0. Deassert -> next instruction transfers.
- Target wrap: pc=0xFFFFFFFC, imm=+8 -> target=0x00000004. TARGET_SHIFT=2 build with imm=+1 -> target=pc+4.
